// File: rtl/calc_pkg.sv
// Shared constants, state encoding and width helpers for the calculator keypad-entry path.
package calc_pkg;

   localparam logic [7:0] KEY_CLR = 8'hC0;
   localparam logic [7:0] KEY_EQ  = 8'hE0;
   localparam logic [7:0] KEY_ADD = 8'hF0;
   localparam logic [7:0] KEY_SUB = 8'hF1;
   localparam logic [7:0] KEY_MUL = 8'hF2;
   localparam logic [7:0] KEY_DIV = 8'hF3;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [7:0] {
      S_IDLE    = 8'b0000_0001,
      S_ENTER_A = 8'b0000_0010,
      S_OP_WAIT = 8'b0000_0100,
      S_ENTER_B = 8'b0000_1000,
      S_CALC    = 8'b0001_0000,
      S_CONVERT = 8'b0010_0000,
      S_SHOW    = 8'b0100_0000,
      S_ERROR   = 8'b1000_0000
   } state_e;

   function automatic int pow10(input int d);
      int p;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   // Bits needed to hold 10^d - 1.
   function automatic int clog2_pow10(input int d);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++)
         if ((longint'(1) << i) < longint'(pow10(d))) w = i + 1;
      return w;
   endfunction

   function automatic logic key_is_digit(input logic [7:0] k);
      return (k[7:4] == 4'h0) && (k[3:0] <= 4'd9);
   endfunction

   function automatic logic key_is_op(input logic [7:0] k);
      return k[7:2] == KEY_ADD[7:2];
   endfunction

endpackage

// File: rtl/calc_entry_fsm_if.sv
// Keypad, calculation-unit handshake and display bus of the entry controller.
interface calc_entry_fsm_if #(parameter int DIGITS = 2) ();

   localparam int OPW   = calc_pkg::clog2_pow10(DIGITS);
   localparam int RES_W = 2 * OPW;
   localparam int DISP  = 2 * DIGITS;

   logic [7:0]        key_code;
   logic              key_pressed;
   logic              calc_req;
   logic              calc_ack;
   logic [OPW-1:0]    op_a;
   logic [OPW-1:0]    op_b;
   logic [1:0]        op_code;
   logic [RES_W-1:0]  calc_result;
   logic              calc_neg;
   logic              calc_err;
   logic [4*DISP-1:0] disp_bcd;
   logic [DISP-1:0]   disp_blank;
   logic              disp_neg;
   logic              disp_err;
   logic              busy;

   modport slave (
      input  key_code, key_pressed, calc_ack, calc_result, calc_neg, calc_err,
      output calc_req, op_a, op_b, op_code, disp_bcd, disp_blank, disp_neg, disp_err, busy
   );

   modport master (
      output key_code, key_pressed, calc_ack, calc_result, calc_neg, calc_err,
      input  calc_req, op_a, op_b, op_code, disp_bcd, disp_blank, disp_neg, disp_err, busy
   );

endinterface

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle, done pulses RES_W cycles after start.
module calc_bin2bcd #(
   parameter int RES_W = 14,
   parameter int DISP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [RES_W-1:0]  bin,
   output logic [4*DISP-1:0] bcd,
   output logic              done
);

   localparam int BW = 4 * DISP;
   localparam int CW = $clog2(RES_W + 1);

   logic [BW-1:0]    bcd_q, bcd_d;
   logic [RES_W-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;
   logic             done_q, done_d;
   logic [BW-1:0]    src_bcd, adj_bcd;
   logic [RES_W-1:0] src_sh;

   // The start cycle performs the first shift itself so the last one lands RES_W cycles later.
   assign src_bcd = start ? '0 : bcd_q;
   assign src_sh  = start ? bin : sh_q;

   generate
      for (genvar gi = 0; gi < DISP; gi++) begin : g_adj
         assign adj_bcd[4*gi +: 4] = (src_bcd[4*gi +: 4] >= 4'd5) ?
                                     src_bcd[4*gi +: 4] + 4'd3 : src_bcd[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      bcd_d  = bcd_q;
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = 1'b0;
      if (start) begin
         {bcd_d, sh_d} = {adj_bcd, src_sh} << 1;
         cnt_d = CW'(RES_W - 1);
         run_d = 1'b1;
      end else if (run_q) begin
         {bcd_d, sh_d} = {adj_bcd, src_sh} << 1;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_q  <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         bcd_q  <= bcd_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad entry controller: operand accumulation, calc-unit handshake, result display.
module calc_entry_fsm
   import calc_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input logic        clk,
   input logic        rst,
   calc_entry_fsm_if.slave bus
);

   localparam int OPW   = clog2_pow10(DIGITS);
   localparam int RES_W = 2 * OPW;
   localparam int DISP  = 2 * DIGITS;
   localparam int BCD_W = 4 * DIGITS;
   localparam int DB_W  = 4 * DISP;

   state_e           state_q, state_d;
   logic             pressed_q;
   logic [OPW-1:0]   a_q, a_d, b_q, b_d;
   logic [BCD_W-1:0] ent_bcd_q, ent_bcd_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [RES_W-1:0] res_q, res_d;
   logic             neg_q, neg_d;

   logic             key_ev, is_dig, is_opk, is_eq, is_clr;
   logic [3:0]       key_dig;
   logic [OPW-1:0]   dig_ext;
   logic             can_append, chain_ok, conv_start, conv_done;
   logic [DB_W-1:0]  conv_bcd;
   logic [2:0]       res_sig;

   assign key_ev     = bus.key_pressed & ~pressed_q;
   assign is_dig     = key_ev & key_is_digit(bus.key_code);
   assign is_opk     = key_ev & key_is_op(bus.key_code);
   assign is_eq      = key_ev & (bus.key_code == KEY_EQ);
   assign is_clr     = key_ev & (bus.key_code == KEY_CLR);
   assign key_dig    = bus.key_code[3:0];
   assign dig_ext    = OPW'(key_dig);
   assign can_append = cnt_q < 3'(DIGITS);
   assign chain_ok   = ~neg_q & (res_q < RES_W'(pow10(DIGITS)));
   // Clear in the ack cycle wins, so it must also suppress the conversion start.
   assign conv_start = (state_q == S_CALC) & bus.calc_ack & ~bus.calc_err & ~is_clr;

   always_comb begin
      res_sig = 3'd1;
      for (int i = 1; i < DIGITS; i++)
         if (conv_bcd[4*i +: 4] != 4'd0) res_sig = 3'(i + 1);
   end

   calc_bin2bcd #(.RES_W(RES_W), .DISP(DISP)) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (bus.calc_result),
      .bcd   (conv_bcd),
      .done  (conv_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pressed_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         ent_bcd_q <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         res_q     <= '0;
         neg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pressed_q <= bus.key_pressed;
         a_q       <= a_d;
         b_q       <= b_d;
         ent_bcd_q <= ent_bcd_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         res_q     <= res_d;
         neg_q     <= neg_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      ent_bcd_d = ent_bcd_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      res_d     = res_q;
      neg_d     = neg_q;
      if (is_clr) begin
         state_d   = S_IDLE;
         a_d       = '0;
         b_d       = '0;
         ent_bcd_d = '0;
         cnt_d     = '0;
         op_d      = '0;
         res_d     = '0;
         neg_d     = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (is_dig) begin
               state_d   = S_ENTER_A;
               a_d       = dig_ext;
               ent_bcd_d = BCD_W'(key_dig);
               cnt_d     = 3'd1;
            end
            S_ENTER_A: begin
               if (is_dig) begin
                  if (can_append) begin
                     a_d       = (a_q << 3) + (a_q << 1) + dig_ext;
                     ent_bcd_d = (ent_bcd_q << 4) | BCD_W'(key_dig);
                     cnt_d     = cnt_q + 3'd1;
                  end
               end else if (is_opk) begin
                  op_d    = bus.key_code[1:0];
                  state_d = S_OP_WAIT;
               end
            end
            S_OP_WAIT: begin
               if (is_opk) begin
                  op_d = bus.key_code[1:0];
               end else if (is_dig) begin
                  state_d   = S_ENTER_B;
                  b_d       = dig_ext;
                  ent_bcd_d = BCD_W'(key_dig);
                  cnt_d     = 3'd1;
               end
            end
            S_ENTER_B: begin
               if (is_dig) begin
                  if (can_append) begin
                     b_d       = (b_q << 3) + (b_q << 1) + dig_ext;
                     ent_bcd_d = (ent_bcd_q << 4) | BCD_W'(key_dig);
                     cnt_d     = cnt_q + 3'd1;
                  end
               end else if (is_eq) begin
                  state_d = S_CALC;
               end
            end
            S_CALC: if (bus.calc_ack) begin
               res_d   = bus.calc_result;
               neg_d   = bus.calc_neg;
               state_d = bus.calc_err ? S_ERROR : S_CONVERT;
            end
            S_CONVERT: if (conv_done) state_d = S_SHOW;
            S_SHOW: begin
               if (is_dig) begin
                  state_d   = S_ENTER_A;
                  a_d       = dig_ext;
                  b_d       = '0;
                  ent_bcd_d = BCD_W'(key_dig);
                  cnt_d     = 3'd1;
               end else if (is_opk && chain_ok) begin
                  state_d   = S_OP_WAIT;
                  a_d       = res_q[OPW-1:0];
                  ent_bcd_d = conv_bcd[BCD_W-1:0];
                  cnt_d     = res_sig;
                  op_d      = bus.key_code[1:0];
               end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin : disp_comb
      logic nz;
      bus.disp_bcd   = '0;
      bus.disp_blank = '1;
      bus.disp_neg   = 1'b0;
      bus.disp_err   = 1'b0;
      nz             = 1'b0;
      case (state_q)
         S_ENTER_A, S_OP_WAIT, S_ENTER_B, S_CALC, S_CONVERT: begin
            bus.disp_bcd = DB_W'(ent_bcd_q);
            for (int i = 0; i < DISP; i++) bus.disp_blank[i] = (i >= int'(cnt_q));
         end
         S_SHOW: begin
            bus.disp_bcd = conv_bcd;
            bus.disp_neg = neg_q;
            // Blank leading zeros from the top down; digit 0 always stays lit.
            for (int i = DISP - 1; i >= 0; i--) begin
               nz = nz | (conv_bcd[4*i +: 4] != 4'd0);
               bus.disp_blank[i] = ~nz & (i != 0);
            end
         end
         S_ERROR: bus.disp_err = 1'b1;
         default: bus.disp_blank = ~DISP'(1);
      endcase
   end

   assign bus.calc_req = (state_q == S_CALC);
   assign bus.busy     = (state_q == S_CALC) | (state_q == S_CONVERT);
   assign bus.op_a     = a_q;
   assign bus.op_b     = b_q;
   assign bus.op_code  = op_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Scenario bench for calc_entry_fsm: queued expected calc transactions, per-scenario checks.
module tb_calc_entry_fsm;
   import calc_pkg::*;

   localparam int DIGITS = 2;
   localparam int OPW    = 7;
   localparam int RES_W  = 14;
   localparam int DISP   = 4;
   localparam int DV_W   = 4 * DISP + DISP + 2;

   typedef struct {
      int a; int b; int op; int res; bit neg; bit err;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;
   txn_t sb_q[$];

   calc_entry_fsm_if #(.DIGITS(DIGITS)) bus ();
   calc_entry_fsm #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [4*DISP-1:0] bcd_of(input int v);
      logic [4*DISP-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < DISP; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [DISP-1:0] blank_n(input int nd);
      logic [DISP-1:0] m;
      for (int i = 0; i < DISP; i++) m[i] = (i >= nd);
      return m;
   endfunction

   function automatic int ndig(input int v);
      int n, x;
      n = 1;
      x = v;
      while (x >= 10) begin x = x / 10; n++; end
      return n;
   endfunction

   function automatic logic [DV_W-1:0] dv(input int v, input int nd, input bit neg);
      return {bcd_of(v), blank_n(nd), neg, 1'b0};
   endfunction

   function automatic logic [DV_W-1:0] cur_dv();
      return {bus.disp_bcd, bus.disp_blank, bus.disp_neg, bus.disp_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] code, input int hold);
      bus.key_code    = code;
      bus.key_pressed = 1'b1;
      repeat (hold) tick();
      bus.key_pressed = 1'b0;
      bus.key_code    = 8'h00;
      tick();
   endtask

   task automatic push(input int a, input int b, input int op, input int res, input bit neg, input bit err);
      txn_t t;
      t.a = a; t.b = b; t.op = op; t.res = res; t.neg = neg; t.err = err;
      sb_q.push_back(t);
   endtask

   // Consumes one queued transaction: checks the request, answers with ack, optionally times SHOW.
   task automatic serve_calc(input bit full);
      txn_t t;
      int n;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("FAIL sb_empty: calc requested with no expected transaction queued");
         return;
      end
      t = sb_q.pop_front();
      n = 0;
      while (bus.calc_req !== 1'b1 && n < 20) begin tick(); n++; end
      tests_run++;
      if (bus.calc_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL req_timeout: calc_req=%b after %0d cycles, required 1", bus.calc_req, n);
         return;
      end
      tests_run++;
      if ({bus.op_a, bus.op_b, bus.op_code} !== {OPW'(t.a), OPW'(t.b), 2'(t.op)}) begin
         tests_failed++;
         $display("FAIL operands: got a=%0d b=%0d op=%0d, required a=%0d b=%0d op=%0d",
                  bus.op_a, bus.op_b, bus.op_code, t.a, t.b, t.op);
      end
      repeat (2) tick();
      tests_run++;
      if ({bus.calc_req, bus.busy} !== 2'b11) begin
         tests_failed++;
         $display("FAIL req_hold: got req/busy=%b, required 11", {bus.calc_req, bus.busy});
      end
      bus.calc_result = RES_W'(t.res);
      bus.calc_neg    = t.neg;
      bus.calc_err    = t.err;
      bus.calc_ack    = 1'b1;
      tick();
      bus.calc_ack    = 1'b0;
      bus.calc_result = '0;
      bus.calc_neg    = 1'b0;
      bus.calc_err    = 1'b0;
      $display("[TB] calc a=%0d b=%0d op=%0d -> res=%0d neg=%0d err=%0d", t.a, t.b, t.op, t.res, t.neg, t.err);
      tests_run++;
      if (bus.calc_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL req_drop: calc_req=%b after ack, required 0", bus.calc_req);
      end
      if (full && !t.err) begin
         n = 0;
         while (bus.busy === 1'b1 && n < 100) begin tick(); n++; end
         tests_run++;
         if (n != RES_W) begin
            tests_failed++;
            $display("FAIL show_latency: busy cleared %0d cycles after ack+1, required %0d", n, RES_W);
         end
      end
   endtask

   task automatic test_reset();
      bus.key_code = 8'h00; bus.key_pressed = 1'b0; bus.calc_ack = 1'b0;
      bus.calc_result = '0; bus.calc_neg = 1'b0; bus.calc_err = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      tests_run++;
      if (cur_dv() !== dv(0, 1, 0)) begin
         tests_failed++; $display("FAIL reset_disp: got %h required %h", cur_dv(), dv(0, 1, 0));
      end
      tests_run++;
      if ({bus.calc_req, bus.busy, bus.op_a, bus.op_b, bus.op_code} !== '0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: req=%b busy=%b a=%0d b=%0d op=%0d, required all 0",
                  bus.calc_req, bus.busy, bus.op_a, bus.op_b, bus.op_code);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_add();
      press(8'h01, 1);
      tests_run++;
      if (cur_dv() !== dv(1, 1, 0)) begin tests_failed++; $display("FAIL add_disp_1: got %h required %h", cur_dv(), dv(1, 1, 0)); end
      press(8'h02, 1);
      tests_run++;
      if (cur_dv() !== dv(12, 2, 0)) begin tests_failed++; $display("FAIL add_disp_12: got %h required %h", cur_dv(), dv(12, 2, 0)); end
      press(KEY_ADD, 1);
      press(8'h03, 1);
      press(8'h04, 1);
      tests_run++;
      if (cur_dv() !== dv(34, 2, 0)) begin tests_failed++; $display("FAIL add_disp_34: got %h required %h", cur_dv(), dv(34, 2, 0)); end
      press(KEY_EQ, 1);
      push(12, 34, OP_ADD, 46, 1'b0, 1'b0);
      tests_run++;
      if (cur_dv() !== dv(34, 2, 0)) begin tests_failed++; $display("FAIL add_calc_hold: got %h required %h", cur_dv(), dv(34, 2, 0)); end
      serve_calc(1'b1);
      tests_run++;
      if (cur_dv() !== dv(46, 2, 0)) begin tests_failed++; $display("FAIL add_show: got %h required %h", cur_dv(), dv(46, 2, 0)); end
   endtask

   task automatic test_saturate();
      repeat (3) press(8'h09, 1);
      tests_run++;
      if ({cur_dv(), bus.op_a} !== {dv(99, 2, 0), OPW'(99)}) begin
         tests_failed++; $display("FAIL sat_a: got disp=%h a=%0d required disp=%h a=99", cur_dv(), bus.op_a, dv(99, 2, 0));
      end
      press(KEY_MUL, 1);
      press(8'h09, 1);
      press(8'h09, 1);
      press(8'h09, 1);
      press(KEY_EQ, 1);
      push(99, 99, OP_MUL, 9801, 1'b0, 1'b0);
      serve_calc(1'b1);
      tests_run++;
      if (cur_dv() !== dv(9801, 4, 0)) begin tests_failed++; $display("FAIL sat_show: got %h required %h", cur_dv(), dv(9801, 4, 0)); end
   endtask

   task automatic test_negative();
      press(8'h00, 1);
      press(8'h05, 1);
      tests_run++;
      if (cur_dv() !== dv(5, 2, 0)) begin tests_failed++; $display("FAIL neg_disp_05: got %h required %h", cur_dv(), dv(5, 2, 0)); end
      press(KEY_SUB, 1);
      press(8'h00, 1);
      press(8'h07, 1);
      press(KEY_EQ, 1);
      push(5, 7, OP_SUB, 2, 1'b1, 1'b0);
      serve_calc(1'b1);
      tests_run++;
      if (cur_dv() !== dv(2, ndig(2), 1)) begin tests_failed++; $display("FAIL neg_show: got %h required %h", cur_dv(), dv(2, 1, 1)); end
      press(KEY_ADD, 1);
      tests_run++;
      if ({cur_dv(), bus.busy, bus.op_code} !== {dv(2, 1, 1), 1'b0, OP_SUB}) begin
         tests_failed++; $display("FAIL neg_no_chain: got disp=%h busy=%b op=%0d required disp=%h busy=0 op=1",
                                  cur_dv(), bus.busy, bus.op_code, dv(2, 1, 1));
      end
   endtask

   task automatic test_error();
      press(8'h08, 1);
      press(KEY_DIV, 1);
      press(8'h00, 1);
      press(KEY_EQ, 1);
      push(8, 0, OP_DIV, 0, 1'b0, 1'b1);
      serve_calc(1'b1);
      tests_run++;
      if ({bus.disp_blank, bus.disp_err, bus.busy} !== {4'hF, 1'b1, 1'b0}) begin
         tests_failed++; $display("FAIL err_enter: blank=%b err=%b busy=%b required 1111/1/0", bus.disp_blank, bus.disp_err, bus.busy);
      end
      press(8'h05, 1);
      press(KEY_EQ, 1);
      tests_run++;
      if ({bus.disp_blank, bus.disp_err, bus.calc_req} !== {4'hF, 1'b1, 1'b0}) begin
         tests_failed++; $display("FAIL err_sticky: blank=%b err=%b req=%b required 1111/1/0", bus.disp_blank, bus.disp_err, bus.calc_req);
      end
      press(KEY_CLR, 1);
      tests_run++;
      if ({cur_dv(), bus.op_a, bus.op_code} !== {dv(0, 1, 0), OPW'(0), 2'd0}) begin
         tests_failed++; $display("FAIL err_clear: got disp=%h a=%0d op=%0d required disp=%h a=0 op=0",
                                  cur_dv(), bus.op_a, bus.op_code, dv(0, 1, 0));
      end
   endtask

   task automatic test_replace_chain();
      press(8'h03, 1);
      press(KEY_ADD, 1);
      press(KEY_MUL, 1);
      tests_run++;
      if ({cur_dv(), bus.op_code} !== {dv(3, 1, 0), OP_MUL}) begin
         tests_failed++; $display("FAIL op_replace: got disp=%h op=%0d required disp=%h op=2", cur_dv(), bus.op_code, dv(3, 1, 0));
      end
      press(8'h04, 1);
      press(KEY_EQ, 1);
      push(3, 4, OP_MUL, 12, 1'b0, 1'b0);
      serve_calc(1'b1);
      press(KEY_ADD, 1);
      tests_run++;
      if ({cur_dv(), bus.op_a, bus.op_code, bus.busy} !== {dv(12, 2, 0), OPW'(12), OP_ADD, 1'b0}) begin
         tests_failed++; $display("FAIL chain_opwait: got disp=%h a=%0d op=%0d busy=%b required disp=%h a=12 op=0 busy=0",
                                  cur_dv(), bus.op_a, bus.op_code, bus.busy, dv(12, 2, 0));
      end
      press(8'h05, 1);
      press(KEY_EQ, 1);
      push(12, 5, OP_ADD, 17, 1'b0, 1'b0);
      serve_calc(1'b1);
      tests_run++;
      if (cur_dv() !== dv(17, 2, 0)) begin tests_failed++; $display("FAIL chain_show: got %h required %h", cur_dv(), dv(17, 2, 0)); end
   endtask

   task automatic test_clear_convert();
      press(8'h06, 1);
      press(KEY_ADD, 1);
      press(8'h07, 1);
      press(KEY_EQ, 1);
      push(6, 7, OP_ADD, 13, 1'b0, 1'b0);
      serve_calc(1'b0);
      repeat (3) tick();
      tests_run++;
      if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL conv_busy: busy=%b required 1", bus.busy); end
      bus.key_code    = KEY_CLR;
      bus.key_pressed = 1'b1;
      tick();
      tests_run++;
      if ({cur_dv(), bus.busy} !== {dv(0, 1, 0), 1'b0}) begin
         tests_failed++; $display("FAIL conv_clear: got disp=%h busy=%b required disp=%h busy=0", cur_dv(), bus.busy, dv(0, 1, 0));
      end
      bus.key_pressed = 1'b0;
      tick();
      press(8'h07, 20);
      tests_run++;
      if ({cur_dv(), bus.op_a} !== {dv(7, 1, 0), OPW'(7)}) begin
         tests_failed++; $display("FAIL held_key: got disp=%h a=%0d required disp=%h a=7", cur_dv(), bus.op_a, dv(7, 1, 0));
      end
      bus.calc_result = RES_W'(99);
      bus.calc_ack    = 1'b1;
      tick();
      bus.calc_ack    = 1'b0;
      bus.calc_result = '0;
      repeat (RES_W + 3) tick();
      tests_run++;
      if ({cur_dv(), bus.busy, bus.calc_req} !== {dv(7, 1, 0), 2'b00}) begin
         tests_failed++; $display("FAIL late_ack: got disp=%h busy=%b req=%b required disp=%h busy=0 req=0",
                                  cur_dv(), bus.busy, bus.calc_req, dv(7, 1, 0));
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_saturate();
      test_negative();
      test_error();
      test_replace_chain();
      test_clear_convert();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
